// File: rtl/v_hier_drv.sv
// v_hier_drv
//   Driver/checker for the far end of the v_hier_sub avec/qvec interface.
//   A start request launches a burst of incrementing vectors on avec, one
//   per cycle. Each returned qvec is sampled LAT cycles after its vector was
//   driven and compared against avec ^ INV_MASK. Mismatches are counted
//   (saturating), the first mismatching index is recorded, and done pulses
//   once at the end of the burst.
//
// Ports
//   clk            in   rising-edge clock
//   reset_l        in   synchronous active-low reset
//   start          in   begin a burst (sampled only in IDLE)
//   count[7:0]     in   burst length (sampled with start)
//   seed[W-1:0]    in   first vector value (sampled with start)
//   avec[W-1:0]    out  stimulus vector
//   qvec[W-1:0]    in   response vector
//   busy           out  high in RUN and DRAIN
//   done           out  one-cycle pulse at burst end
//   err_cnt[E-1:0] out  saturating mismatch count of the last burst
//   first_err_vld  out  at least one mismatch in the last burst
//   first_err_idx  out  vector index of the first mismatch

module v_hier_drv #(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      LAT      = 1,
  parameter logic [WIDTH-1:0] INV_MASK = '0,
  parameter int unsigned      ERRW     = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [7:0]       count,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] avec,
  input  logic [WIDTH-1:0] qvec,
  output logic             busy,
  output logic             done,
  output logic [ERRW-1:0]  err_cnt,
  output logic             first_err_vld,
  output logic [7:0]       first_err_idx
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_cnt;
  logic [7:0]       r_idx;
  logic [3:0]       r_drn;
  logic [WIDTH-1:0] r_avec;

  // Check pipeline: stage 0 captures the vector driven this cycle, stage
  // LAT-1 is compared against qvec on the following edge.
  logic             r_pv [LAT];
  logic [WIDTH-1:0] r_pe [LAT];
  logic [7:0]       r_pi [LAT];

  logic [ERRW-1:0]  r_err_cnt;
  logic             r_fev;
  logic [7:0]       r_fei;

  logic             w_accept;
  logic             w_last;
  logic             w_drain_end;
  logic             w_mis;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_last      = (r_idx == (r_cnt - 8'd1));
  assign w_drain_end = (r_drn == 4'(LAT - 1));
  assign w_mis       = r_pv[LAT-1] && (qvec != r_pe[LAT-1]);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (count != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drain_end) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst sequencing: avec is cleared on the DRAIN->DONE edge so it already
  // reads zero during the done cycle.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_drn  <= '0;
      r_avec <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= count;
            r_idx <= '0;
            r_drn <= '0;
            if (count != 8'd0) begin
              r_avec <= seed;
            end
          end
        end
        RUN: begin
          r_idx <= r_idx + 8'd1;
          if (!w_last) begin
            r_avec <= r_avec + WIDTH'(1);
          end
        end
        DRAIN: begin
          r_drn <= r_drn + 4'd1;
          if (w_drain_end) begin
            r_avec <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= '0;
        r_pi[i] <= '0;
      end
    end else begin
      r_pv[0] <= (r_state == RUN);
      r_pe[0] <= r_avec ^ INV_MASK;
      r_pi[0] <= r_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pi[i] <= r_pi[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_err_cnt <= '0;
      r_fev     <= 1'b0;
      r_fei     <= '0;
    end else if (w_accept) begin
      r_err_cnt <= '0;
      r_fev     <= 1'b0;
      r_fei     <= '0;
    end else if (w_mis) begin
      if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + ERRW'(1);
      end
      if (!r_fev) begin
        r_fev <= 1'b1;
        r_fei <= r_pi[LAT-1];
      end
    end
  end

  assign avec          = r_avec;
  assign err_cnt       = r_err_cnt;
  assign first_err_vld = r_fev;
  assign first_err_idx = r_fei;

endmodule

// File: tb/tb_v_hier_drv.sv
// tb_v_hier_drv
//   Two drivers (LAT=1/no mask/ERRW=4 and LAT=3/mask 0xA/ERRW=3) share the
//   start/count/seed inputs. Each has its own responder that delays avec by
//   LAT cycles, applies the expected inversion and an optional fault.
//   Expected avec/busy/done per cycle and end-of-burst statistics come from
//   the burst timing rules and a per-vector mismatch model.

module tb_v_hier_drv;

  localparam int LA = 1;
  localparam int LB = 3;
  localparam logic [3:0] MA = 4'h0;
  localparam logic [3:0] MB = 4'hA;
  localparam int EA = 4;
  localparam int EB = 3;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       start;
  logic [7:0] count;
  logic [3:0] seed;

  logic [3:0] a_avec, a_q, a_fei_dummy;
  logic       a_busy, a_done, a_fev;
  logic [3:0] a_err;
  logic [7:0] a_fei;

  logic [3:0] b_avec, b_q;
  logic       b_busy, b_done, b_fev;
  logic [2:0] b_err;
  logic [7:0] b_fei;

  int fmode;
  int fbit;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  v_hier_drv #(.WIDTH(4), .LAT(LA), .INV_MASK(MA), .ERRW(EA)) u_a (
    .clk(clk), .reset_l(reset_l), .start(start), .count(count), .seed(seed),
    .avec(a_avec), .qvec(a_q), .busy(a_busy), .done(a_done),
    .err_cnt(a_err), .first_err_vld(a_fev), .first_err_idx(a_fei)
  );

  v_hier_drv #(.WIDTH(4), .LAT(LB), .INV_MASK(MB), .ERRW(EB)) u_b (
    .clk(clk), .reset_l(reset_l), .start(start), .count(count), .seed(seed),
    .avec(b_avec), .qvec(b_q), .busy(b_busy), .done(b_done),
    .err_cnt(b_err), .first_err_vld(b_fev), .first_err_idx(b_fei)
  );

  function automatic logic [3:0] corrupt(input logic [3:0] v, input int mode, input int b);
    logic [3:0] bm;
    bm = 4'b0001 << b;
    case (mode)
      1: return v & ~bm;
      2: return v | bm;
      3: return ~v;
      default: return v;
    endcase
  endfunction

  // Responders: LAT-deep delay of the inverted vector, then the fault.
  logic [3:0] da [LA];
  logic [3:0] db [LB];

  always @(posedge clk) begin
    da[0] <= a_avec ^ MA;
    for (int i = 1; i < LA; i++) da[i] <= da[i-1];
    db[0] <= b_avec ^ MB;
    for (int i = 1; i < LB; i++) db[i] <= db[i-1];
  end

  always_comb begin
    a_q = corrupt(da[LA-1], fmode, fbit);
    b_q = corrupt(db[LB-1], fmode, fbit);
  end

  assign a_fei_dummy = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Mismatch statistics expected for a burst, one vector at a time.
  task automatic model(input logic [3:0] sd, input int n, input logic [3:0] m,
                       input int errw, output int ec, output int fv, output int fi);
    logic [3:0] e;
    ec = 0; fv = 0; fi = 0;
    for (int k = 0; k < n; k++) begin
      e = (sd + 4'(k)) ^ m;
      if (corrupt(e, fmode, fbit) != e) begin
        if (ec < (1 << errw) - 1) ec++;
        if (fv == 0) begin
          fv = 1;
          fi = k;
        end
      end
    end
  endtask

  // Cycle j after the accepting edge T (cycle T+j).
  task automatic chk_dut(input string p, input int j, input int n, input int sd, input int L,
                         input int av, input int bz, input int dn,
                         input int er, input int fv, input int fi,
                         input int xe, input int xv, input int xi);
    int ea, eb, ed, dcyc;
    if (n == 0) begin
      ea = 0; eb = 0; ed = (j == 1); dcyc = 1;
    end else begin
      dcyc = n + L + 1;
      if (j <= n) begin
        ea = (sd + j - 1) & 15; eb = 1; ed = 0;
      end else if (j <= n + L) begin
        ea = (sd + n - 1) & 15; eb = 1; ed = 0;
      end else begin
        ea = 0; eb = 0; ed = (j == dcyc);
      end
    end
    check({p, "_avec"}, av, ea);
    check({p, "_busy"}, bz, eb);
    check({p, "_done"}, dn, ed);
    if (j >= dcyc) begin
      check({p, "_err_cnt"}, er, xe);
      check({p, "_first_err_vld"}, fv, xv);
      check({p, "_first_err_idx"}, fi, xi);
    end
  endtask

  task automatic run_burst(input logic [3:0] sd, input int n, input int ign_j);
    int ae, av, ai, be, bv, bi;
    model(sd, n, MA, EA, ae, av, ai);
    model(sd, n, MB, EB, be, bv, bi);
    start = 1'b1;
    count = 8'(n);
    seed  = sd;
    @(posedge clk); #1;
    for (int j = 1; j <= n + LB + 2; j++) begin
      count = 8'($urandom);
      seed  = 4'($urandom);
      chk_dut("a", j, n, int'(sd), LA, int'(a_avec), int'(a_busy), int'(a_done),
              int'(a_err), int'(a_fev), int'(a_fei), ae, av, ai);
      chk_dut("b", j, n, int'(sd), LB, int'(b_avec), int'(b_busy), int'(b_done),
              int'(b_err), int'(b_fev), int'(b_fei), be, bv, bi);
      start = (j == ign_j);
      if (start) count = 8'd3;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic reset_mid(input logic [3:0] sd);
    start = 1'b1;
    count = 8'd10;
    seed  = sd;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      check("rst_a_avec", int'(a_avec), int'(4'(sd + 4'(j - 1))));
      check("rst_b_busy", int'(b_busy), 1);
      if (j == 3) reset_l = 1'b0;
      @(posedge clk); #1;
    end
    reset_l = 1'b1;
    check("rst_a_avec0", int'(a_avec), 0);
    check("rst_b_avec0", int'(b_avec), 0);
    check("rst_a_busy0", int'(a_busy), 0);
    check("rst_b_busy0", int'(b_busy), 0);
    check("rst_a_err0", int'(a_err), 0);
    check("rst_b_fev0", int'(b_fev), 0);
    for (int j = 0; j < 12; j++) begin
      check("rst_a_nodone", int'(a_done), 0);
      check("rst_b_nodone", int'(b_done), 0);
      check("rst_b_idle", int'(b_busy), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, ign;
    reset_l = 1'b0;
    start   = 1'b0;
    count   = '0;
    seed    = '0;
    fmode   = 0;
    fbit    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_avec", int'(a_avec), 0);
    check("reset_a_busy", int'(a_busy), 0);
    check("reset_a_done", int'(a_done), 0);
    check("reset_a_err", int'(a_err), 0);
    check("reset_a_fev", int'(a_fev), 0);
    check("reset_a_fei", int'(a_fei), int'(a_fei_dummy));
    check("reset_b_busy", int'(b_busy), 0);
    check("reset_b_err", int'(b_err), 0);
    reset_l = 1'b1;
    @(posedge clk); #1;

    fmode = 0; run_burst(4'd3, 4, -1);
    fmode = 1; fbit = 2; run_burst(4'd3, 4, -1);
    fmode = 0; run_burst(4'd5, 0, -1);
    run_burst(4'd14, 4, -1);
    fmode = 3; run_burst(4'($urandom), 20, 5);
    reset_mid(4'($urandom));
    fmode = 0; run_burst(4'($urandom), 10, -1);

    repeat (25) begin
      fmode = int'($urandom_range(0, 3));
      fbit  = int'($urandom_range(0, 3));
      n     = int'($urandom_range(0, 40));
      ign   = -1;
      if (n >= 2 && $urandom_range(0, 1) == 1) ign = int'($urandom_range(2, n + LA));
      run_burst(4'($urandom), n, ign);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
